// File: rtl/rob_pkg.sv
// Shared reorder-buffer sizes and the per-entry record layout.
package rob_pkg;

  localparam int unsigned ROB_DEPTH  = 16;
  localparam int unsigned ROB_IDX_W  = $clog2(ROB_DEPTH);
  localparam int unsigned PREG_WIDTH = 6;
  localparam int unsigned AREG_WIDTH = 5;
  localparam int unsigned ROB_DATA_W = 32;
  localparam int unsigned ROB_PC_W   = 12;
  localparam int unsigned ROB_TAG_W  = 6;

  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic                  rd_we;
    logic [AREG_WIDTH-1:0] areg;
    logic [PREG_WIDTH-1:0] preg;
    logic [PREG_WIDTH-1:0] old_preg;
    logic [ROB_PC_W-1:0]   pc;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Modulo-Depth wrap pointer with increment enable and synchronous active-low clear.
module rob_ptr #(
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     clr_ni,
  input  logic                     inc_i,
  output logic [$clog2(Depth)-1:0] ptr_o
);

  localparam int unsigned W = $clog2(Depth);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = (ptr_q == W'(Depth - 1)) ? '0 : ptr_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order allocate, out-of-order completion on two ports, in-order retire.
// Optional flush port enabled by defining ROB_FLUSH_EN.
module rob #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PREG_WIDTH = 6,
  parameter int unsigned AREG_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef ROB_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic                     alloc_valid,
  input  logic                     alloc_rd_we,
  input  logic [AREG_WIDTH-1:0]    alloc_areg,
  input  logic [PREG_WIDTH-1:0]    alloc_preg,
  input  logic [PREG_WIDTH-1:0]    alloc_old_preg,
  input  logic [11:0]              alloc_pc,
  output logic                     alloc_ready,
  output logic [5:0]               rob_num,
  input  logic                     cmpl0_valid,
  input  logic [5:0]               cmpl0_tag,
  input  logic [DATA_WIDTH-1:0]    cmpl0_data,
  input  logic                     cmpl1_valid,
  input  logic [5:0]               cmpl1_tag,
  input  logic [DATA_WIDTH-1:0]    cmpl1_data,
  output logic                     retire_valid,
  output logic                     retire_rd_we,
  output logic [AREG_WIDTH-1:0]    retire_areg,
  output logic [PREG_WIDTH-1:0]    retire_preg,
  output logic [DATA_WIDTH-1:0]    retire_data,
  output logic                     free_push,
  output logic [PREG_WIDTH-1:0]    free_reg,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  import rob_pkg::*;

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam logic [IdxW:0] FullCnt = (IdxW + 1)'(DEPTH);

  logic flush_act;
`ifdef ROB_FLUSH_EN
  assign flush_act = flush;
`else
  assign flush_act = 1'b0;
`endif

  rob_entry_t      entries_q [DEPTH];
  rob_entry_t      entries_d [DEPTH];
  rob_entry_t      head_e;
  logic [IdxW-1:0] head, tail;
  logic [IdxW:0]   count_q, count_d;
  logic            clr_n, do_alloc, do_retire;

  assign clr_n     = rst & ~flush_act;
  assign head_e    = entries_q[head];
  assign full      = (count_q == FullCnt);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign do_alloc  = alloc_valid & ~full & clr_n;
  // Gated by reset/flush so a discarded head never reaches the ARF or free list.
  assign do_retire = head_e.busy & head_e.done & clr_n;

  assign alloc_ready  = ~full;
  assign rob_num      = 6'(tail);
  assign retire_valid = do_retire;
  assign retire_rd_we = head_e.rd_we;
  assign retire_areg  = head_e.areg;
  assign retire_preg  = head_e.preg;
  assign retire_data  = head_e.data;
  assign free_push    = do_retire & head_e.rd_we;
  assign free_reg     = head_e.old_preg;

  rob_ptr #(.Depth(DEPTH)) u_head (
    .clk_i  (clk),
    .clr_ni (clr_n),
    .inc_i  (do_retire),
    .ptr_o  (head)
  );

  rob_ptr #(.Depth(DEPTH)) u_tail (
    .clk_i  (clk),
    .clr_ni (clr_n),
    .inc_i  (do_alloc),
    .ptr_o  (tail)
  );

  // cmpl1 is applied after cmpl0 so it wins a same-tag collision.
  always_comb begin
    entries_d = entries_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (cmpl0_valid && cmpl0_tag == 6'(i) && entries_q[i].busy) begin
        entries_d[i].done = 1'b1;
        entries_d[i].data = cmpl0_data;
      end
      if (cmpl1_valid && cmpl1_tag == 6'(i) && entries_q[i].busy) begin
        entries_d[i].done = 1'b1;
        entries_d[i].data = cmpl1_data;
      end
    end
    if (do_retire) begin
      entries_d[head] = '0;
    end
    if (do_alloc) begin
      entries_d[tail].busy     = 1'b1;
      entries_d[tail].done     = 1'b0;
      entries_d[tail].rd_we    = alloc_rd_we;
      entries_d[tail].areg     = alloc_areg;
      entries_d[tail].preg     = alloc_preg;
      entries_d[tail].old_preg = alloc_old_preg;
      entries_d[tail].pc       = alloc_pc;
      entries_d[tail].data     = '0;
    end
  end

  always_comb begin
    count_d = count_q + (IdxW + 1)'(do_alloc) - (IdxW + 1)'(do_retire);
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for rob: a queue-of-instructions model predicts retires, a monitor checks them.
module tb_rob;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        alloc_valid, alloc_rd_we;
  logic [4:0]  alloc_areg;
  logic [5:0]  alloc_preg, alloc_old_preg;
  logic [11:0] alloc_pc;
  logic        alloc_ready;
  logic [5:0]  rob_num;
  logic        cmpl0_valid, cmpl1_valid;
  logic [5:0]  cmpl0_tag, cmpl1_tag;
  logic [31:0] cmpl0_data, cmpl1_data;
  logic        retire_valid, retire_rd_we;
  logic [4:0]  retire_areg;
  logic [5:0]  retire_preg;
  logic [31:0] retire_data;
  logic        free_push;
  logic [5:0]  free_reg;
  logic        full, empty;
  logic [4:0]  count;

  always #5 clk = ~clk;

  rob dut (
    .clk            (clk),
    .rst            (rst),
`ifdef ROB_FLUSH_EN
    .flush          (flush),
`endif
    .alloc_valid    (alloc_valid),
    .alloc_rd_we    (alloc_rd_we),
    .alloc_areg     (alloc_areg),
    .alloc_preg     (alloc_preg),
    .alloc_old_preg (alloc_old_preg),
    .alloc_pc       (alloc_pc),
    .alloc_ready    (alloc_ready),
    .rob_num        (rob_num),
    .cmpl0_valid    (cmpl0_valid),
    .cmpl0_tag      (cmpl0_tag),
    .cmpl0_data     (cmpl0_data),
    .cmpl1_valid    (cmpl1_valid),
    .cmpl1_tag      (cmpl1_tag),
    .cmpl1_data     (cmpl1_data),
    .retire_valid   (retire_valid),
    .retire_rd_we   (retire_rd_we),
    .retire_areg    (retire_areg),
    .retire_preg    (retire_preg),
    .retire_data    (retire_data),
    .free_push      (free_push),
    .free_reg       (free_reg),
    .full           (full),
    .empty          (empty),
    .count          (count)
  );

  typedef struct {
    int          idx;
    bit          we;
    logic [4:0]  ar;
    logic [5:0]  pr;
    logic [5:0]  op;
    bit          done;
    logic [31:0] data;
  } rec_t;

  rec_t mq[$];     // in-flight instructions, oldest first
  rec_t exp_q[$];  // retires expected, consumed by the monitor
  int   tail_m = 0;
  int   n_total = 0;
  int   n_pass = 0;
  bit   run = 1'b1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin : monitor
    rec_t e;
    if (run) begin
      if (retire_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_retire", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("retire_rd_we", retire_rd_we, e.we);
          chk("retire_areg", retire_areg, e.ar);
          chk("retire_preg", retire_preg, e.pr);
          chk("retire_data", retire_data, e.data);
          chk("free_push", free_push, e.we);
          chk("free_reg", free_reg, e.op);
        end
      end else begin
        chk("idle_free_push", free_push, 0);
      end
    end
  end

  task automatic step(input bit rn, input bit fl, input bit av, input bit we,
                      input logic [4:0] ar, input logic [5:0] pr, input logic [5:0] op,
                      input bit c0v, input logic [5:0] c0t, input logic [31:0] c0d,
                      input bit c1v, input logic [5:0] c1t, input logic [31:0] c1d);
    int   n0;
    bit   ret;
    rec_t r;
    n0  = mq.size();
    ret = rn && !fl && n0 > 0 && mq[0].done;
    if (ret) exp_q.push_back(mq[0]);
    rst = rn; flush = fl;
    alloc_valid = av; alloc_rd_we = we; alloc_areg = ar; alloc_preg = pr;
    alloc_old_preg = op; alloc_pc = 12'($urandom);
    cmpl0_valid = c0v; cmpl0_tag = c0t; cmpl0_data = c0d;
    cmpl1_valid = c1v; cmpl1_tag = c1t; cmpl1_data = c1d;
    @(negedge clk);
    chk("count", count, n0);
    chk("full", full, n0 == 16);
    chk("empty", empty, n0 == 0);
    chk("alloc_ready", alloc_ready, n0 < 16);
    chk("rob_num", rob_num, tail_m);
    chk("retire_valid", retire_valid, ret);
    if (!rn || fl) begin
      mq.delete();
      tail_m = 0;
    end else begin
      if (ret) void'(mq.pop_front());
      foreach (mq[i]) if (c0v && mq[i].idx == int'(c0t)) begin mq[i].done = 1; mq[i].data = c0d; end
      foreach (mq[i]) if (c1v && mq[i].idx == int'(c1t)) begin mq[i].done = 1; mq[i].data = c1d; end
      if (av && n0 < 16) begin
        r.idx = tail_m; r.we = we; r.ar = ar; r.pr = pr; r.op = op; r.done = 0; r.data = '0;
        mq.push_back(r);
        tail_m = (tail_m + 1) % 16;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_cycle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alloc(input bit we, input logic [5:0] pr, input logic [5:0] op);
    step(1, 0, 1, we, 5'(pr), pr, op, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic comp(input logic [5:0] t, input logic [31:0] d);
    step(1, 0, 0, 0, 0, 0, 0, 1, t, d, 0, 0, 0);
  endtask

  function automatic logic [5:0] pick_tag();
    if (mq.size() > 0 && $urandom_range(0, 3) != 0)
      return 6'(mq[$urandom_range(0, mq.size() - 1)].idx);
    return 6'($urandom_range(0, 63));
  endfunction

  initial begin
    rst = 1'b0; flush = 1'b0;
    alloc_valid = 0; alloc_rd_we = 0; alloc_areg = '0; alloc_preg = '0;
    alloc_old_preg = '0; alloc_pc = '0;
    cmpl0_valid = 0; cmpl0_tag = '0; cmpl0_data = '0;
    cmpl1_valid = 0; cmpl1_tag = '0; cmpl1_data = '0;
    repeat (2) @(posedge clk);
    #1;

    // Single instruction at minimum latency.
    alloc(1, 6'd33, 6'd5);
    comp(6'd0, 32'h1234);
    idle();
    idle();

    // Fill to full, overflow attempt, then retire-while-full and wrap.
    reset_cycle();
    for (int i = 0; i < 16; i++) alloc(1, 6'(i + 10), 6'(i));
    alloc(1, 6'd60, 6'd61);
    comp(6'd0, 32'hCAFE0000);
    alloc(1, 6'd50, 6'd51);
    alloc(0, 6'd52, 6'd53);
    for (int i = 15; i >= 0; i--) comp(6'(i), 32'h100 + 32'(i));
    for (int i = 0; i < 17; i++) idle();

    // Out-of-order completion, in-order retire.
    reset_cycle();
    for (int i = 0; i < 3; i++) alloc(1, 6'(20 + i), 6'(40 + i));
    comp(6'd2, 32'h22);
    comp(6'd1, 32'h11);
    comp(6'd0, 32'h00);
    for (int i = 0; i < 4; i++) idle();

    // Same-tag collision on both ports, completion to an empty slot.
    reset_cycle();
    for (int i = 0; i < 4; i++) alloc(i[0], 6'(i), 6'(i + 1));
    step(1, 0, 0, 0, 0, 0, 0, 1, 6'd3, 32'hA, 1, 6'd3, 32'hB);
    comp(6'd7, 32'hDEAD);
    step(1, 0, 0, 0, 0, 0, 0, 1, 6'd0, 32'h70, 1, 6'd1, 32'h71);
    comp(6'd2, 32'h72);
    for (int i = 0; i < 5; i++) idle();

`ifdef ROB_FLUSH_EN
    // Flush with a retire-ready head and a concurrent allocation.
    reset_cycle();
    for (int i = 0; i < 5; i++) alloc(1, 6'(i), 6'(i + 8));
    comp(6'd0, 32'h55);
    step(1, 1, 1, 1, 5'd1, 6'd2, 6'd3, 1, 6'd1, 32'h66, 0, 0, 0);
    idle();
`endif

    // Randomized traffic with occasional reset (and flush when built in).
    for (int k = 0; k < 3000; k++) begin
      bit          rn, fl, av, c0v, c1v;
      logic [5:0]  t0, t1;
      rn  = ($urandom_range(0, 399) != 0);
      fl  = 1'b0;
`ifdef ROB_FLUSH_EN
      fl  = ($urandom_range(0, 199) == 0);
`endif
      av  = ($urandom_range(0, 9) < 6);
      c0v = $urandom_range(0, 1) == 1;
      c1v = $urandom_range(0, 2) == 0;
      t0  = pick_tag();
      t1  = ($urandom_range(0, 7) == 0) ? t0 : pick_tag();
      step(rn, fl, av, $urandom_range(0, 1) == 1, 5'($urandom), 6'($urandom), 6'($urandom),
           c0v, t0, $urandom, c1v, t1, $urandom);
    end

    // Drain everything still in flight.
    for (int k = 0; k < 100 && mq.size() > 0; k++) begin
      int t;
      t = -1;
      foreach (mq[i]) if (!mq[i].done && t < 0) t = mq[i].idx;
      if (t >= 0) comp(6'(t), 32'($urandom));
      else idle();
    end
    idle();

    chk("scoreboard_drained", exp_q.size(), 0);
    chk("model_drained", mq.size(), 0);
    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 Parameter: DEPTH, default 16, number of reorder-buffer entries (power of two).
REQ-002 Parameter: PREG_WIDTH, default 6, physical register tag width.
REQ-003 Parameter: AREG_WIDTH, default 5, architectural register index width.
REQ-004 Parameter: DATA_WIDTH, default 32, result data width.
REQ-005 Port: clk  in  1  single clock, all state updates on rising edge.
REQ-006 Port: rst  in  1  reset, synchronous, active-low.
REQ-007 Port: alloc_valid  in  1  dispatch requests a new entry this cycle.
REQ-008 Port: alloc_rd_we  in  1  instruction writes a destination register.
REQ-009 Port: alloc_areg / alloc_preg / alloc_old_preg  in  AREG_WIDTH / PREG_WIDTH / PREG_WIDTH  arch rd, new phys rd, previous phys mapping of rd.
REQ-010 Port: alloc_pc  in  12  instruction PC, stored for debug.
REQ-011 Port: alloc_ready  out  1  entry available (not full).
REQ-012 Port: rob_num  out  6  index of the entry the next allocation receives (tail, zero-extended).
REQ-013 Port: cmpl0_valid, cmpl0_tag, cmpl0_data  in  1, 6, DATA_WIDTH  ALU0 completion: ROB index and result.
REQ-014 Port: cmpl1_valid, cmpl1_tag, cmpl1_data  in  1, 6, DATA_WIDTH  ALU1 completion.
REQ-015 Port: retire_valid, retire_rd_we, retire_areg, retire_preg, retire_data  out  1, 1, AREG_WIDTH, PREG_WIDTH, DATA_WIDTH  head commit to the ARF.
REQ-016 Port: free_push, free_reg  out  1, PREG_WIDTH  old phys reg returned to the free pool.
REQ-017 Port: full, empty  out  1, 1  occupancy flags; count  out  clog2(DEPTH)+1  occupied entries.

Function
REQ-018 An allocation occurs at an edge when alloc_valid && !full: tail entry written with the alloc fields, busy=1, done=0; tail increments modulo DEPTH.
REQ-019 alloc_valid while full shall be ignored with no state change; alloc_ready = !full and shall not account for a same-cycle retire.
REQ-020 Completion: cmpl valid with tag < DEPTH addressing a busy entry sets done=1 and stores data at the edge; a completion to a non-busy entry shall be ignored.
REQ-021 Both ports completing the same tag in one cycle: cmpl1 data shall be stored.
REQ-022 Retire is combinational from head: retire_valid = head busy && head done; other retire_* outputs reflect head fields.
REQ-023 free_push = retire_valid && head rd_we; free_reg = head old_preg.
REQ-024 On a retire edge the head entry is cleared (busy=0, done=0) and head increments modulo DEPTH; at most one retire per cycle.
REQ-025 Minimum latency: allocate at edge N, complete at edge N+1, retire_valid high in cycle after N+1, entry freed at edge N+2.
REQ-026 Simultaneous allocate and retire: count unchanged; permitted when full (retire frees, alloc still blocked that cycle per REQ-019).
REQ-027 Allocation into an empty buffer shall not retire in the same cycle (done=0).
REQ-028 count = occupied entries; full = (count==DEPTH); empty = (count==0); pointers wrap DEPTH-1 -> 0.

Reset
REQ-029 While rst==0 at an edge: head=tail=0, count=0, all busy/done cleared, stored fields cleared.
REQ-030 Post-reset outputs: alloc_ready=1, rob_num=0, retire_valid=0, free_push=0, full=0, empty=1, count=0; reset mid-operation discards all in-flight entries without any free_push.

Configuration
REQ-031 Macro ROB_FLUSH_EN defined: input port flush (1 bit, active-high); flush at an edge clears all entries and pointers as in REQ-029, suppresses retire/free_push that cycle, and takes priority over allocation and completion.
REQ-032 ROB_FLUSH_EN undefined: no flush port and no flush logic.

Structure
REQ-033 Package rob_pkg shall hold ROB_DEPTH, ROB_IDX_W, PREG_WIDTH, AREG_WIDTH and the rob_entry_t struct (busy, done, rd_we, areg, preg, old_preg, pc, data).
REQ-034 One sub-module, rob_ptr: modulo-DEPTH wrap pointer with increment enable and synchronous active-low clear, instantiated for head and tail.

Verification
REQ-035 Reset, alloc preg=33 old=5 rd_we=1 at rob_num 0, cmpl0 tag 0 data 0x1234 -> next cycle retire_valid=1, retire_data=0x1234, free_push=1, free_reg=5; empty=1 after.
REQ-036 Allocate 16 without completion -> full=1, alloc_ready=0, count=16; 17th alloc ignored, rob_num stays 0.
REQ-037 Alloc entries 0,1,2; complete 2 then 1 then 0 -> no retire until 0 done, then retires 0,1,2 on consecutive cycles.
REQ-038 Full buffer, head done, alloc_valid=1 -> one retire, count=15, no alloc that cycle; next cycle alloc into index 0 (wrap).
REQ-039 cmpl0 and cmpl1 both tag 3 data 0xA / 0xB -> entry 3 stores 0xB; completion to empty index 7 -> no state change.
REQ-040 With ROB_FLUSH_EN, 5 busy entries, flush=1 with alloc_valid=1 -> count=0, empty=1, rob_num=0, free_push=0.
